hmem_arbiter: RTL and testbench

HMEM_ARBITER -- requirements
Module: hmem_arbiter

---
 rtl/hmem_arbiter_pkg.sv | 24 ++
 rtl/hmem_arbiter_if.sv | 34 +++
 rtl/hmem_arbiter_rr_pick2.sv | 18 +
 rtl/hmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_hmem_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hmem_arbiter_pkg.sv
// Shared types for the higher-memory arbiter slice.
// Contents:
//   memory_operation_e - request opcode carried on every higher-memory port
//   arb_state_e        - arbiter FSM states
//   OWNER_*            - one-hot encodings presented on the arbiter's owner output
package torrence_types;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    STORE   = 2'd1,
    CLFLUSH = 2'd2
  } memory_operation_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_C0   = 2'b01;
  localparam logic [1:0] OWNER_C1   = 2'b10;

endpackage

// File: rtl/hmem_arbiter_if.sv
// Interfaces used by the arbiter.
//   reset_if         - carries the asynchronous active-high reset.
//   higher_memory_if - word-granular request/fulfil channel between a cache
//                      miss path and main memory.
//     memory    modport: the side that answers requests (req_* in, fulfil out)
//     requester modport: the side that issues requests (mirror of memory)
interface reset_if;
  logic reset;
  modport sink   (input  reset);
  modport source (output reset);
endinterface

interface higher_memory_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import torrence_types::*;

  logic              req_valid;
  memory_operation_e req_operation;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_store_word;
  logic              req_fulfilled;
  logic [DATA_W-1:0] req_loaded_word;

  modport memory (
    input  req_valid, req_operation, req_address, req_store_word,
    output req_fulfilled, req_loaded_word
  );
  modport requester (
    output req_valid, req_operation, req_address, req_store_word,
    input  req_fulfilled, req_loaded_word
  );
endinterface

// File: rtl/hmem_arbiter_rr_pick2.sv
// Two-requester round-robin picker.
// Ports:
//   i_req0, i_req1 - request lines of client 0 / client 1
//   i_last_owner   - client that held the port last (0 = client 0, 1 = client 1)
//   o_grant0/1     - at most one asserted; on a tie the client that did not
//                    own the port last wins
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_owner,
  output logic o_grant0,
  output logic o_grant1
);

  assign o_grant0 = i_req0 & (~i_req1 |  i_last_owner);
  assign o_grant1 = i_req1 & (~i_req0 | ~i_last_owner);

endmodule

// File: rtl/hmem_arbiter.sv
// Arbiter sharing one main-memory port between the I-cache (client 0) and
// D-cache (client 1) miss paths. A client keeps the port for as long as it
// holds req_valid, so a writeback followed by an allocate stays in one tenure.
// Ports:
//   clk            - clock
//   rst_if         - asynchronous active-high reset
//   c0_if, c1_if   - client ports (memory side)
//   mem_if         - downstream port to main memory (requester side)
//   owner          - one-hot current owner (01 = c0, 10 = c1, 00 = none)
//   protocol_error - sticky: a tenure ended part-way through a cache line
module hmem_arbiter
  import torrence_types::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  reset_if.sink             rst_if,
  higher_memory_if.memory   c0_if,
  higher_memory_if.memory   c1_if,
  higher_memory_if.requester mem_if,
  output logic [1:0]        owner,
  output logic              protocol_error
);

  localparam int CNT_W = $clog2(LINE_WORDS) + 1;

  arb_state_e        r_state;
  logic              r_last_owner;   // 0 = client 0, 1 = client 1
  logic [CNT_W-1:0]  r_word_cnt;
  logic              r_protocol_error;

  logic              w_rst;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_req_valid;
  memory_operation_e w_req_operation;
  logic [ADDR_W-1:0] w_req_address;

  // The count wraps at 2*LINE_WORDS; only its position within a line matters.
  function automatic logic line_misaligned(input logic [CNT_W-1:0] cnt);
    return (cnt & CNT_W'(LINE_WORDS - 1)) != '0;
  endfunction

  assign w_rst = rst_if.reset;

  rr_pick2 u_pick (
    .i_req0       (c0_if.req_valid),
    .i_req1       (c1_if.req_valid),
    .i_last_owner (r_last_owner),
    .o_grant0     (w_grant0),
    .o_grant1     (w_grant1)
  );

  // Combinational forwarding. A fulfil that lands in the owner's release
  // cycle is not passed back, since the owner has already stopped asking.
  always_comb begin
    w_req_valid           = 1'b0;
    w_req_operation       = LOAD;
    w_req_address         = '0;
    mem_if.req_store_word = '0;
    c0_if.req_fulfilled   = 1'b0;
    c0_if.req_loaded_word = '0;
    c1_if.req_fulfilled   = 1'b0;
    c1_if.req_loaded_word = '0;
    owner                 = OWNER_NONE;
    case (r_state)
      ST_IDLE: ;
      ST_OWN0: begin
        w_req_valid           = c0_if.req_valid;
        w_req_operation       = c0_if.req_operation;
        w_req_address         = c0_if.req_address;
        mem_if.req_store_word = c0_if.req_store_word;
        c0_if.req_fulfilled   = mem_if.req_fulfilled & c0_if.req_valid;
        c0_if.req_loaded_word = c0_if.req_valid ? mem_if.req_loaded_word : '0;
        owner                 = OWNER_C0;
      end
      ST_OWN1: begin
        w_req_valid           = c1_if.req_valid;
        w_req_operation       = c1_if.req_operation;
        w_req_address         = c1_if.req_address;
        mem_if.req_store_word = c1_if.req_store_word;
        c1_if.req_fulfilled   = mem_if.req_fulfilled & c1_if.req_valid;
        c1_if.req_loaded_word = c1_if.req_valid ? mem_if.req_loaded_word : '0;
        owner                 = OWNER_C1;
      end
      default: begin
        w_req_valid           = 1'bx;
        w_req_operation       = memory_operation_e'(2'bxx);
        w_req_address         = 'x;
        mem_if.req_store_word = 'x;
        c0_if.req_fulfilled   = 1'bx;
        c0_if.req_loaded_word = 'x;
        c1_if.req_fulfilled   = 1'bx;
        c1_if.req_loaded_word = 'x;
        owner                 = 2'bxx;
      end
    endcase
  end

  assign mem_if.req_valid     = w_req_valid;
  assign mem_if.req_operation = w_req_operation;
  assign mem_if.req_address   = w_req_address;
  assign protocol_error       = r_protocol_error;

  // Every tenure passes through ST_IDLE on release, so tenures never abut.
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state          <= ST_IDLE;
      r_last_owner     <= 1'b1;
      r_word_cnt       <= '0;
      r_protocol_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant0) begin
            r_state    <= ST_OWN0;
            r_word_cnt <= '0;
          end else if (w_grant1) begin
            r_state    <= ST_OWN1;
            r_word_cnt <= '0;
          end
        end
        ST_OWN0: begin
          if (!c0_if.req_valid) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b0;
            if (line_misaligned(r_word_cnt)) r_protocol_error <= 1'b1;
          end else if (mem_if.req_fulfilled) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
          end
        end
        ST_OWN1: begin
          if (!c1_if.req_valid) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            if (line_misaligned(r_word_cnt)) r_protocol_error <= 1'b1;
          end else if (mem_if.req_fulfilled) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hmem_arbiter.sv
// Directed bench for hmem_arbiter: tenure-level reference model compared on
// every falling edge, plus hand-computed spot checks on each scenario.
module tb_hmem_arbiter;
  import torrence_types::*;

  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  reset_if rst_if_i ();
  higher_memory_if #(.ADDR_W(32), .DATA_W(32)) c0_if_i ();
  higher_memory_if #(.ADDR_W(32), .DATA_W(32)) c1_if_i ();
  higher_memory_if #(.ADDR_W(32), .DATA_W(32)) mem_if_i ();

  logic [1:0] owner;
  logic       protocol_error;

  hmem_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst_if         (rst_if_i),
    .c0_if          (c0_if_i),
    .c1_if          (c1_if_i),
    .mem_if         (mem_if_i),
    .owner          (owner),
    .protocol_error (protocol_error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, who owned it last, how many words
  // the current tenure has received, and the sticky error.
  int   m_cur   = -1;   // -1 none, 0 client 0, 1 client 1
  int   m_last  = 1;
  int   m_words = 0;
  logic m_perr  = 1'b0;

  always @(negedge clk) begin
    logic        v0, v1, f;
    logic [1:0]  e_owner;
    logic        e_mv;
    logic [31:0] ml;
    v0 = c0_if_i.req_valid;
    v1 = c1_if_i.req_valid;
    f  = mem_if_i.req_fulfilled;
    ml = mem_if_i.req_loaded_word;
    if (rst_if_i.reset) begin
      m_cur = -1; m_last = 1; m_words = 0; m_perr = 1'b0;
    end
    e_owner = (m_cur == 0) ? 2'b01 : (m_cur == 1) ? 2'b10 : 2'b00;
    e_mv    = (m_cur == 0) ? v0 : (m_cur == 1) ? v1 : 1'b0;
    chk("m_owner", owner, e_owner);
    chk("m_mem_valid", mem_if_i.req_valid, e_mv);
    chk("m_c0_fulfilled", c0_if_i.req_fulfilled, (m_cur == 0) && v0 && f);
    chk("m_c1_fulfilled", c1_if_i.req_fulfilled, (m_cur == 1) && v1 && f);
    chk("m_protocol_error", protocol_error, m_perr);
    if (m_cur >= 0) begin
      chk("m_c0_loaded", c0_if_i.req_loaded_word, (m_cur == 0 && v0) ? ml : 32'h0);
      chk("m_c1_loaded", c1_if_i.req_loaded_word, (m_cur == 1 && v1) ? ml : 32'h0);
      chk("m_mem_addr", mem_if_i.req_address,
          (m_cur == 0) ? c0_if_i.req_address : c1_if_i.req_address);
      chk("m_mem_store", mem_if_i.req_store_word,
          (m_cur == 0) ? c0_if_i.req_store_word : c1_if_i.req_store_word);
      chk("m_mem_op", mem_if_i.req_operation,
          (m_cur == 0) ? c0_if_i.req_operation : c1_if_i.req_operation);
    end
    if (!rst_if_i.reset) begin
      if (m_cur < 0) begin
        if (v0 && v1)  m_cur = (m_last == 0) ? 1 : 0;
        else if (v0)   m_cur = 0;
        else if (v1)   m_cur = 1;
        m_words = 0;
      end else if (!((m_cur == 0) ? v0 : v1)) begin
        if ((m_words % LW) != 0) m_perr = 1'b1;
        m_last = m_cur;
        m_cur  = -1;
      end else if (f) begin
        m_words++;
      end
    end
  end

  task automatic step(input logic v0, input logic v1, input logic f);
    @(posedge clk);
    #1;
    cyc++;
    c0_if_i.req_valid        = v0;
    c0_if_i.req_operation    = LOAD;
    c0_if_i.req_address      = 32'h1000_0000 + 32'(cyc);
    c0_if_i.req_store_word   = 32'hC0C0_0000 + 32'(cyc);
    c1_if_i.req_valid        = v1;
    c1_if_i.req_operation    = STORE;
    c1_if_i.req_address      = 32'h2000_0000 + 32'(cyc);
    c1_if_i.req_store_word   = 32'hC1C1_0000 + 32'(cyc);
    mem_if_i.req_fulfilled   = f;
    mem_if_i.req_loaded_word = 32'hD000_0000 + 32'(cyc * 7);
    #1;
  endtask

  task automatic clear_inputs();
    c0_if_i.req_valid        = 1'b0;
    c0_if_i.req_operation    = LOAD;
    c0_if_i.req_address      = '0;
    c0_if_i.req_store_word   = '0;
    c1_if_i.req_valid        = 1'b0;
    c1_if_i.req_operation    = LOAD;
    c1_if_i.req_address      = '0;
    c1_if_i.req_store_word   = '0;
    mem_if_i.req_fulfilled   = 1'b0;
    mem_if_i.req_loaded_word = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_if_i.reset = 1'b1;
    clear_inputs();
    #1;
    chk("rst_owner", owner, 2'b00);
    chk("rst_mem_valid", mem_if_i.req_valid, 1'b0);
    chk("rst_protocol_error", protocol_error, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_if_i.reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_if_i.reset = 1'b1;
    clear_inputs();
    do_reset();

    // Lone c1 request, one aligned line
    step(0, 1, 0);
    chk("c1only_latency_owner", owner, 2'b00);
    chk("c1only_latency_mem_valid", mem_if_i.req_valid, 1'b0);
    step(0, 1, 1);
    chk("c1only_owner", owner, 2'b10);
    chk("c1only_fulfilled", c1_if_i.req_fulfilled, 1'b1);
    chk("c1only_addr", mem_if_i.req_address, 32'h2000_0000 + 32'(cyc));
    repeat (3) step(0, 1, 1);
    step(0, 0, 0);
    chk("c1only_release_mem_valid", mem_if_i.req_valid, 1'b0);
    chk("c1only_release_owner", owner, 2'b10);
    step(0, 0, 0);
    chk("c1only_idle_owner", owner, 2'b00);
    chk("c1only_perr", protocol_error, 1'b0);

    // Tie after reset: c0 first, one idle cycle, then c1
    do_reset();
    step(1, 1, 0);
    chk("tie_latency_owner", owner, 2'b00);
    step(1, 1, 1);
    chk("tie_first_owner", owner, 2'b01);
    chk("tie_c1_starved", c1_if_i.req_fulfilled, 1'b0);
    chk("tie_c0_loaded", c0_if_i.req_loaded_word, 32'hD000_0000 + 32'(cyc * 7));
    repeat (3) step(1, 1, 1);
    step(0, 1, 0);
    chk("tie_c0_release_owner", owner, 2'b01);
    step(0, 1, 0);
    chk("tie_gap_owner", owner, 2'b00);
    step(0, 1, 1);
    chk("tie_second_owner", owner, 2'b10);
    repeat (3) step(0, 1, 1);
    step(0, 0, 0);
    step(0, 0, 0);

    // c1 dirty miss: writeback + allocate held in one tenure while c0 waits
    step(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1);
      chk("dirty_owner", owner, 2'b10);
      chk("dirty_c0_fulfilled", c0_if_i.req_fulfilled, 1'b0);
    end
    step(1, 0, 0);
    step(1, 0, 0);
    chk("dirty_gap_owner", owner, 2'b00);
    step(1, 0, 1);
    chk("dirty_c0_owner", owner, 2'b01);
    repeat (3) step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("dirty_perr", protocol_error, 1'b0);

    // Short tenure: 3 words, and a fulfil coincident with release is dropped
    step(0, 1, 0);
    repeat (3) step(0, 1, 1);
    step(0, 0, 1);
    chk("short_release_c1_fulfilled", c1_if_i.req_fulfilled, 1'b0);
    chk("short_release_mem_valid", mem_if_i.req_valid, 1'b0);
    step(0, 0, 0);
    chk("short_idle_owner", owner, 2'b00);
    chk("short_perr_set", protocol_error, 1'b1);
    step(1, 0, 0);
    repeat (4) step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("short_perr_sticky", protocol_error, 1'b1);

    // Reset in the middle of a c0 tenure
    do_reset();
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 1);
    chk("midrst_pre_owner", owner, 2'b01);
    #1;
    rst_if_i.reset = 1'b1;
    #1;
    chk("midrst_owner", owner, 2'b00);
    chk("midrst_mem_valid", mem_if_i.req_valid, 1'b0);
    chk("midrst_perr", protocol_error, 1'b0);
    @(posedge clk);
    #1;
    rst_if_i.reset = 1'b0;
    clear_inputs();
    step(1, 1, 0);
    step(1, 1, 0);
    chk("midrst_first_grant", owner, 2'b01);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("midrst_final_perr", protocol_error, 1'b0);

    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
